// File: rtl/nios_system_main_memory_arbiter.sv
// ============================================================================
// Module   : nios_system_main_memory_arbiter
// Purpose  : Two-port Avalon-MM arbiter in front of the single-port on-chip
//            main memory (1-cycle read latency). Fixed priority (port A) by
//            default; define MAIN_MEMORY_ARB_ROUND_ROBIN_EN for alternation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nios_system_main_memory_arbiter #(
   parameter int ADDR_W   = 17,
   parameter int DATA_W   = 32,
   parameter int HOLD_MAX = 4
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic [ADDR_W-1:0]     a_address,
   input  logic [DATA_W/8-1:0]   a_byteenable,
   input  logic                  a_read,
   input  logic                  a_write,
   input  logic [DATA_W-1:0]     a_writedata,
   output logic                  a_waitrequest,
   output logic [DATA_W-1:0]     a_readdata,
   output logic                  a_readdatavalid,

   input  logic [ADDR_W-1:0]     b_address,
   input  logic [DATA_W/8-1:0]   b_byteenable,
   input  logic                  b_read,
   input  logic                  b_write,
   input  logic [DATA_W-1:0]     b_writedata,
   output logic                  b_waitrequest,
   output logic [DATA_W-1:0]     b_readdata,
   output logic                  b_readdatavalid,

   output logic [ADDR_W-1:0]     m_address,
   output logic [DATA_W/8-1:0]   m_byteenable,
   output logic                  m_chipselect,
   output logic                  m_write,
   output logic [DATA_W-1:0]     m_writedata,
   output logic                  m_clken,
   input  logic [DATA_W-1:0]     m_readdata
);

   localparam logic       GNT_A   = 1'b0;
   localparam logic       GNT_B   = 1'b1;
   localparam logic [1:0] RD_IDLE = 2'd0;
   localparam logic [1:0] RD_A    = 2'd1;
   localparam logic [1:0] RD_B    = 2'd2;

   logic       last_grant_q, last_grant_d;
   logic [3:0] hold_cnt_q,   hold_cnt_d;
   logic [1:0] rd_own_q,     rd_own_d;

   logic req_a, req_b;
   logic contend_b;
   logic grant_a, grant_b;
   logic sel_wr;

   assign req_a = a_read | a_write;
   assign req_b = b_read | b_write;

`ifdef MAIN_MEMORY_ARB_ROUND_ROBIN_EN
   // Alternation already yields to the other port every cycle of contention.
   always_comb begin
      contend_b = (last_grant_q == GNT_A);
   end
`else
   localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

   always_comb begin
      contend_b = (last_grant_q == GNT_A) && (hold_cnt_q == HOLD_LIM);
   end
`endif

   // No grants at all while reset is held, so waitrequest mirrors the request.
   always_comb begin
      grant_a = ~reset & req_a & (~req_b | ~contend_b);
      grant_b = ~reset & req_b & (~req_a |  contend_b);
   end

   always_comb begin
      last_grant_d = last_grant_q;
      hold_cnt_d   = 4'd0;
      rd_own_d     = RD_IDLE;

      if (grant_a || grant_b) begin
         if (grant_b != last_grant_q) begin
            last_grant_d = grant_b;
            hold_cnt_d   = 4'd1;
         end else if (grant_b ? req_a : req_b) begin
            hold_cnt_d = (hold_cnt_q == 4'hF) ? 4'hF : hold_cnt_q + 4'd1;
         end else begin
            hold_cnt_d = 4'd0;
         end
      end

      if (grant_a && !a_write) begin
         rd_own_d = RD_A;
      end else if (grant_b && !b_write) begin
         rd_own_d = RD_B;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_q <= GNT_B;
         hold_cnt_q   <= 4'd0;
         rd_own_q     <= RD_IDLE;
      end else begin
         last_grant_q <= last_grant_d;
         hold_cnt_q   <= hold_cnt_d;
         rd_own_q     <= rd_own_d;
      end
   end

   // Port A's command is presented whenever B is not granted (idle included).
   always_comb begin
      sel_wr       = grant_b ? b_write : a_write;
      m_address    = grant_b ? b_address   : a_address;
      m_writedata  = grant_b ? b_writedata : a_writedata;
      m_byteenable = sel_wr ? (grant_b ? b_byteenable : a_byteenable) : '1;
      m_chipselect = grant_a | grant_b;
      m_write      = (grant_a | grant_b) & sel_wr;
      m_clken      = 1'b1;
   end

   assign a_waitrequest   = req_a & ~grant_a;
   assign b_waitrequest   = req_b & ~grant_b;
   assign a_readdata      = m_readdata;
   assign b_readdata      = m_readdata;
   assign a_readdatavalid = (rd_own_q == RD_A);
   assign b_readdatavalid = (rd_own_q == RD_B);

endmodule

`default_nettype wire

// File: tb/tb_nios_system_main_memory_arbiter.sv
// Scoreboard bench for nios_system_main_memory_arbiter: a behavioural memory
// plus a reference arbitration model feeding queues checked by a monitor.
`default_nettype none

module tb_nios_system_main_memory_arbiter;

   localparam int ADDR_W   = 17;
   localparam int DATA_W   = 32;
   localparam int BE_W     = 4;
   localparam int HOLD_MAX = 4;
   localparam int DEPTH    = 76800;

   logic clk = 1'b0;
   logic reset;
   logic [ADDR_W-1:0] a_address, b_address, m_address;
   logic [BE_W-1:0]   a_byteenable, b_byteenable, m_byteenable;
   logic a_read, a_write, b_read, b_write;
   logic [DATA_W-1:0] a_writedata, b_writedata, m_writedata, m_readdata;
   logic a_waitrequest, b_waitrequest, a_readdatavalid, b_readdatavalid;
   logic [DATA_W-1:0] a_readdata, b_readdata;
   logic m_chipselect, m_write, m_clken;

   always #5 clk = ~clk;

   nios_system_main_memory_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_MAX(HOLD_MAX)
   ) dut (
      .clk(clk), .reset(reset),
      .a_address(a_address), .a_byteenable(a_byteenable), .a_read(a_read),
      .a_write(a_write), .a_writedata(a_writedata), .a_waitrequest(a_waitrequest),
      .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid),
      .b_address(b_address), .b_byteenable(b_byteenable), .b_read(b_read),
      .b_write(b_write), .b_writedata(b_writedata), .b_waitrequest(b_waitrequest),
      .b_readdata(b_readdata), .b_readdatavalid(b_readdatavalid),
      .m_address(m_address), .m_byteenable(m_byteenable), .m_chipselect(m_chipselect),
      .m_write(m_write), .m_writedata(m_writedata), .m_clken(m_clken),
      .m_readdata(m_readdata)
   );

   function automatic logic [31:0] init_word(int i);
      if (i == 16) return 32'hDEADBEEF;
      if (i == DEPTH - 1) return 32'hFFFFFFFF;
      return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   // Memory behind the arbiter: one-cycle registered read.
   logic [31:0] mem [DEPTH];
   bit mem_ready = 1'b0;
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
         mem_ready <= 1'b1;
      end else if (m_chipselect && m_clken && (int'(m_address) < DEPTH)) begin
         if (m_write) begin
            for (int k = 0; k < BE_W; k++)
               if (m_byteenable[k]) mem[m_address][8*k +: 8] <= m_writedata[8*k +: 8];
         end else begin
            m_readdata <= mem[m_address];
         end
      end
   end

   typedef struct {
      int cyc; bit wa; bit wb; bit cs; bit wr;
      logic [16:0] addr; logic [3:0] be; logic [31:0] wd; byte pat;
   } cmd_t;
   typedef struct { int due; bit port_b; logic [31:0] data; } rd_t;

   cmd_t cmd_q[$];
   rd_t  rd_q[$];
   int   cyc = 0;
   int   n_cmp = 0, n_bad = 0;
   bit   done = 1'b0, fin = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: sample mid-cycle and compare against queued expectations.
   cmd_t mc;
   rd_t  mr;
   byte  mg;
   always @(negedge clk) begin
      if (cmd_q.size() > 0 && cmd_q[0].cyc == cyc) begin
         mc = cmd_q.pop_front();
         check("handshake", {61'd0, a_waitrequest, b_waitrequest, m_chipselect},
               {61'd0, mc.wa, mc.wb, mc.cs});
         if (mc.cs)
            check("command", {10'd0, m_write, m_address, m_byteenable, mc.wr ? m_writedata : 32'd0},
                  {10'd0, mc.wr, mc.addr, mc.be, mc.wr ? mc.wd : 32'd0});
         if (mc.pat != 0) begin
            mg = ((a_read | a_write) && !a_waitrequest) ? "A" :
                 ((b_read | b_write) && !b_waitrequest) ? "B" : "-";
            check("grant_seq", 64'(mg), 64'(mc.pat));
         end
      end
      if (reset) begin
         check("valid_in_reset", {62'd0, a_readdatavalid, b_readdatavalid}, 64'd0);
         while (rd_q.size() > 0 && rd_q[0].due <= cyc) void'(rd_q.pop_front());
      end else if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
         mr = rd_q.pop_front();
         check("rd_strobe", {62'd0, a_readdatavalid, b_readdatavalid},
               mr.port_b ? 64'd1 : 64'd2);
         check("rd_data", 64'(mr.port_b ? b_readdata : a_readdata), 64'(mr.data));
      end else if (a_readdatavalid || b_readdatavalid) begin
         check("rd_spurious", {62'd0, a_readdatavalid, b_readdatavalid}, 64'd0);
      end
      if (done && !fin) begin
         check("drain", 64'(cmd_q.size() + rd_q.size()), 64'd0);
         fin <= 1'b1;
      end
   end

   // Reference model state: who was served last and for how many contended cycles.
   logic [31:0] ref_mem [DEPTH];
   bit last_b;
   int streak;

   task automatic step(input byte pat, output bit ga, output bit gb);
      bit ra, rb;
      cmd_t c;
      rd_t r;
      ra = a_read | a_write;
      rb = b_read | b_write;
      ga = 1'b0;
      gb = 1'b0;
      if (!reset) begin
         if (ra && rb) begin
            if (streak >= HOLD_MAX) gb = !last_b;
`ifdef MAIN_MEMORY_ARB_ROUND_ROBIN_EN
            else gb = !last_b;
`else
            else gb = 1'b0;
`endif
            ga = !gb;
         end else begin
            ga = ra;
            gb = rb;
         end
      end
      c.cyc = cyc; c.wa = ra & !ga; c.wb = rb & !gb; c.cs = ga | gb; c.pat = pat;
      if (gb) begin
         c.wr = b_write; c.addr = b_address; c.wd = b_writedata;
         c.be = b_write ? b_byteenable : 4'hF;
      end else begin
         c.wr = a_write; c.addr = a_address; c.wd = a_writedata;
         c.be = a_write ? a_byteenable : 4'hF;
      end
      cmd_q.push_back(c);
      if (c.cs) begin
         if (c.wr) begin
            for (int k = 0; k < BE_W; k++)
               if (c.be[k]) ref_mem[c.addr][8*k +: 8] = c.wd[8*k +: 8];
         end else begin
            r.due = cyc + 1; r.port_b = gb; r.data = ref_mem[c.addr];
            rd_q.push_back(r);
         end
      end
      if (reset) begin
         last_b = 1'b1; streak = 0;
      end else if (!c.cs) begin
         streak = 0;
      end else if (gb != last_b) begin
         last_b = gb; streak = 1;
      end else begin
         streak = (gb ? ra : rb) ? ((streak < 15) ? streak + 1 : 15) : 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(bit r, bit w, logic [16:0] ad, logic [3:0] be, logic [31:0] wd);
      a_read = r; a_write = w; a_address = ad; a_byteenable = be; a_writedata = wd;
   endtask
   task automatic set_b(bit r, bit w, logic [16:0] ad, logic [3:0] be, logic [31:0] wd);
      b_read = r; b_write = w; b_address = ad; b_byteenable = be; b_writedata = wd;
   endtask
   task automatic idle();
      set_a(0, 0, 17'd0, 4'h0, 32'd0);
      set_b(0, 0, 17'd0, 4'h0, 32'd0);
   endtask
   task automatic rand_cmd(output bit r, output bit w, output logic [16:0] ad,
                           output logic [3:0] be, output logic [31:0] wd);
      w  = ($urandom_range(0, 1) == 1);
      r  = !w;
      ad = ($urandom_range(0, 7) == 0) ? 17'(DEPTH - 1) : 17'($urandom_range(0, 31));
      be = 4'($urandom_range(1, 15));
      wd = $urandom;
   endtask

   initial begin
      bit ga, gb, pa, pb, r, w;
      logic [16:0] ad;
      logic [3:0] be;
      logic [31:0] wd;
      string pat;
      int ia, ib;

      reset = 1'b1;
      idle();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
      last_b = 1'b1;
      streak = 0;
      @(posedge clk);
      #1;
      step(0, ga, gb);
      set_a(1, 0, 17'h10, 4'hF, 32'd0);
      set_b(0, 1, 17'h5, 4'h3, 32'h0BAD0BAD);
      step(0, ga, gb);
      step(0, ga, gb);
      reset = 1'b0;
      idle();
      step(0, ga, gb);

      // Single-port read of a preloaded word.
      set_a(1, 0, 17'h10, 4'hF, 32'd0);
      step("A", ga, gb);
      idle();
      step(0, ga, gb);

      // Byte-lane write into the last word, then read back.
      set_b(0, 1, 17'h12BFF, 4'b0010, 32'h11223344);
      step("B", ga, gb);
      set_b(1, 0, 17'h12BFF, 4'hF, 32'd0);
      step("B", ga, gb);
      idle();
      step(0, ga, gb);

`ifndef MAIN_MEMORY_ARB_ROUND_ROBIN_EN
      // Continuous contended reads under fixed priority.
      pat = "AAAABAAAAB";
      for (int i = 0; i < 10; i++) begin
         set_a(1, 0, 17'(i), 4'hF, 32'd0);
         set_b(1, 0, 17'(40 + i), 4'hF, 32'd0);
         step(pat[i], ga, gb);
      end
      idle();
      step(0, ga, gb);
`endif

      // Continuous contended writes; each master holds its command until accepted.
      set_b(1, 0, 17'h3, 4'hF, 32'd0);
      step(0, ga, gb);
      idle();
      step(0, ga, gb);
`ifdef MAIN_MEMORY_ARB_ROUND_ROBIN_EN
      pat = "ABABABAB";
`else
      pat = "AAAABAAA";
`endif
      ia = 0;
      ib = 0;
      for (int i = 0; i < 8; i++) begin
         set_a(0, 1, 17'(32 + ia), 4'hF, 32'hA0000000 + 32'(ia));
         set_b(0, 1, 17'(48 + ib), 4'hF, 32'hB0000000 + 32'(ib));
         step(pat[i], ga, gb);
         if (ga) ia++;
         if (gb) ib++;
      end
      idle();
      for (int i = 32; i < 56; i++) begin
         set_a(1, 0, 17'(i), 4'hF, 32'd0);
         step(0, ga, gb);
      end
      idle();
      step(0, ga, gb);

      // Back-to-back single-port reads alternating between A and B.
      for (int i = 0; i < 3; i++) begin
         idle();
         set_a(1, 0, 17'h1, 4'hF, 32'd0);
         step("A", ga, gb);
         idle();
         set_b(1, 0, 17'h2, 4'hF, 32'd0);
         step("B", ga, gb);
      end
      idle();
      step(0, ga, gb);

      // Reset lands the cycle after a read is accepted.
      set_a(1, 0, 17'h10, 4'hF, 32'd0);
      step("A", ga, gb);
      reset = 1'b1;
      idle();
      step(0, ga, gb);
      step(0, ga, gb);
      reset = 1'b0;
      set_a(1, 0, 17'h7, 4'hF, 32'd0);
      set_b(1, 0, 17'h8, 4'hF, 32'd0);
      step("A", ga, gb);
      idle();
      step(0, ga, gb);

      // Randomised traffic with occasional reset pulses.
      pa = 1'b0;
      pb = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         if (!pa && $urandom_range(0, 2) != 0) begin
            rand_cmd(r, w, ad, be, wd);
            set_a(r, w, ad, be, wd);
            pa = 1'b1;
         end else if (!pa) begin
            set_a(0, 0, 17'd0, 4'h0, 32'd0);
         end
         if (!pb && $urandom_range(0, 2) != 0) begin
            rand_cmd(r, w, ad, be, wd);
            set_b(r, w, ad, be, wd);
            pb = 1'b1;
         end else if (!pb) begin
            set_b(0, 0, 17'd0, 4'h0, 32'd0);
         end
         reset = ($urandom_range(0, 249) == 0);
         step(0, ga, gb);
         if (reset) begin
            reset = 1'b0;
            pa = 1'b0;
            pb = 1'b0;
         end else begin
            if (ga) pa = 1'b0;
            if (gb) pb = 1'b0;
         end
      end

      idle();
      for (int i = 0; i < 3; i++) step(0, ga, gb);
      done = 1'b1;
      for (int i = 0; i < 5 && !fin; i++) @(posedge clk);
      #1;
      if (!fin) begin
         $display("FAIL drain_timeout: monitor did not finish");
         $fatal(1, "bench stalled");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
